piezo_tone_player: RTL and testbench

Plays a fixed-length square-wave tone on a piezo for each button press. It consumes the debounced, single-cycle rising-edge pulses from the button conditioning stage, which has one bit per button. Each button maps to one note of a C4–C5 scale. It also exports the active note index, so the 7-segment display stage can show it.

---
 rtl/piezo_tone_player_if.sv | 36 +++
 rtl/piezo_tone_player.sv | 141 ++++++++++++++
 tb/tb_piezo_tone_player.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/piezo_tone_player_if.sv
// -----------------------------------------------------------------------------
// piezo_tone_player_if
// Groups the button-trigger input and the tone/display outputs of the piezo
// tone player into one bundle.
//   btn_trig   : one-cycle press pulses, bit i selects note i
//   piezo      : square-wave drive for the piezo
//   busy       : high while a tone plays
//   note_idx   : active or last-played note index
//   note_valid : high once any note has played since reset
// Modports:
//   master : the side that issues presses and observes the player
//   slave  : the tone player itself
// -----------------------------------------------------------------------------
interface piezo_tone_player_if;
  logic [7:0] btn_trig;
  logic       piezo;
  logic       busy;
  logic [2:0] note_idx;
  logic       note_valid;

  modport master (
    output btn_trig,
    input  piezo,
    input  busy,
    input  note_idx,
    input  note_valid
  );

  modport slave (
    input  btn_trig,
    output piezo,
    output busy,
    output note_idx,
    output note_valid
  );
endinterface

// File: rtl/piezo_tone_player.sv
// -----------------------------------------------------------------------------
// piezo_tone_player
// Plays a fixed-length square-wave tone for each button press. Each of the
// eight buttons maps to one note of the C4..C5 scale. A press while a tone is
// playing restarts the tone with the new note. The active note index is
// exported for the display stage.
// Parameters:
//   CLK_HZ     : clock frequency in Hz (elaboration only)
//   DUR_CYCLES : tone length in clock cycles (>= 1)
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous, active-low reset
//   bus : slave side of piezo_tone_player_if (btn_trig in; piezo, busy,
//         note_idx, note_valid out)
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module piezo_tone_player #(
  parameter int CLK_HZ     = 25_000_000,
  parameter int DUR_CYCLES = 12_500_000
) (
  input  logic                 clk,
  input  logic                 rst,
  piezo_tone_player_if.slave   bus
);

  localparam int NOTES = 8;

  // Note frequencies in Hz, index 0 = C4 ... index 7 = C5.
  localparam int FREQ [NOTES] = '{262, 294, 330, 349, 392, 440, 494, 523};

  // The lowest note has the longest half-period, so it sizes the counter.
  // The counter never exceeds HALF-1, so $clog2(HALF_MAX) bits suffice.
  localparam int HALF_MAX = CLK_HZ / (2 * 262);
  localparam int HW       = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;
  localparam int DW       = (DUR_CYCLES > 1) ? $clog2(DUR_CYCLES) : 1;

  localparam logic [DW-1:0] DUR_LAST = DW'(DUR_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  state_t        state_reg,      state_next;
  logic [HW-1:0] half_cnt_reg,   half_cnt_next;
  logic [DW-1:0] dur_cnt_reg,    dur_cnt_next;
  logic          piezo_reg,      piezo_next;
  logic [2:0]    note_idx_reg,   note_idx_next;
  logic          note_valid_reg, note_valid_next;

  // Terminal count (HALF-1) for every note, all elaboration-time constants.
  logic [HW-1:0] half_last [NOTES];

  genvar gi;
  generate
    for (gi = 0; gi < NOTES; gi++) begin : g_half
      assign half_last[gi] = HW'(CLK_HZ / (2 * FREQ[gi]) - 1);
    end
  endgenerate

  logic       trig;
  logic [2:0] trig_idx;

  assign trig = |bus.btn_trig;

  // Priority encoder: scanning from the top down leaves the lowest set bit.
  always_comb begin
    trig_idx = '0;
    for (int i = NOTES - 1; i >= 0; i--) begin
      if (bus.btn_trig[i]) begin
        trig_idx = 3'(i);
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    half_cnt_next   = half_cnt_reg;
    dur_cnt_next    = dur_cnt_reg;
    piezo_next      = piezo_reg;
    note_idx_next   = note_idx_reg;
    note_valid_next = note_valid_reg;

    if (trig) begin
      // A press always starts a fresh tone, including on the expiry cycle.
      state_next      = PLAY;
      note_idx_next   = trig_idx;
      half_cnt_next   = '0;
      dur_cnt_next    = '0;
      piezo_next      = 1'b0;
      note_valid_next = 1'b1;
    end else begin
      case (state_reg)
        PLAY: begin
          if (dur_cnt_reg == DUR_LAST) begin
            state_next    = IDLE;
            half_cnt_next = '0;
            dur_cnt_next  = '0;
            piezo_next    = 1'b0;
          end else begin
            dur_cnt_next = dur_cnt_reg + 1'b1;
            if (half_cnt_reg == half_last[note_idx_reg]) begin
              half_cnt_next = '0;
              piezo_next    = ~piezo_reg;
            end else begin
              half_cnt_next = half_cnt_reg + 1'b1;
            end
          end
        end
        default: begin
          // IDLE: everything holds, note_idx keeps the last-played note.
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      half_cnt_reg   <= '0;
      dur_cnt_reg    <= '0;
      piezo_reg      <= 1'b0;
      note_idx_reg   <= '0;
      note_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      half_cnt_reg   <= half_cnt_next;
      dur_cnt_reg    <= dur_cnt_next;
      piezo_reg      <= piezo_next;
      note_idx_reg   <= note_idx_next;
      note_valid_reg <= note_valid_next;
    end
  end

  // The state is a single flop, so busy is a registered output.
  assign bus.busy       = (state_reg == PLAY);
  assign bus.piezo      = piezo_reg;
  assign bus.note_idx   = note_idx_reg;
  assign bus.note_valid = note_valid_reg;

endmodule

// File: tb/tb_piezo_tone_player.sv
// -----------------------------------------------------------------------------
// tb_piezo_tone_player
// Scoreboard bench for piezo_tone_player at CLK_HZ=8800, DUR_CYCLES=100.
// Half-periods at this clock: 16,14,13,12,11,10,8,8 for notes 0..7.
// The stimulus process pushes one expected output record per clock cycle it
// cares about; the monitor pops and compares on each falling edge.
// -----------------------------------------------------------------------------
module tb_piezo_tone_player;

  localparam int CLK_HZ = 8800;
  localparam int DUR    = 100;

  typedef struct {
    int         cyc;
    logic       piezo;
    logic       busy;
    logic [2:0] note;
    logic       valid;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  exp_t q[$];

  piezo_tone_player_if bus ();

  piezo_tone_player #(
    .CLK_HZ     (CLK_HZ),
    .DUR_CYCLES (DUR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected tone: piezo low for 'half' cycles, then alternating.
  task automatic push_tone(input int s, input int note, input int half, input int n);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      e.cyc   = s + k;
      e.piezo = ((k / half) % 2) == 1;
      e.busy  = 1'b1;
      e.note  = 3'(note);
      e.valid = 1'b1;
      q.push_back(e);
    end
  endtask

  task automatic push_idle(input int s, input int n, input int note, input logic valid);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      e.cyc   = s + k;
      e.piezo = 1'b0;
      e.busy  = 1'b0;
      e.note  = 3'(note);
      e.valid = valid;
      q.push_back(e);
    end
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [7:0] bits);
    bus.btn_trig = bits;
    @(posedge clk);
    #1;
    bus.btn_trig = 8'h00;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      total++;
      $display("FAIL missed cyc=%0d: expected record never compared", e.cyc);
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      total++;
      if (bus.piezo === e.piezo && bus.busy === e.busy &&
          bus.note_idx === e.note && bus.note_valid === e.valid) begin
        passed++;
      end else begin
        $display("FAIL outputs cyc=%0d got piezo=%b busy=%b note=%0d valid=%b required piezo=%b busy=%b note=%0d valid=%b",
                 cyc, bus.piezo, bus.busy, bus.note_idx, bus.note_valid,
                 e.piezo, e.busy, e.note, e.valid);
      end
    end
  end

  initial begin
    int s;
    int s2;
    bus.btn_trig = 8'h00;

    // Reset held three cycles, then 100 quiet cycles.
    push_idle(1, 3, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    push_idle(cyc + 1, 100, 0, 1'b0);
    wait_until(cyc + 100);

    // Basic tone: note 5, half 10.
    s = cyc + 1;
    push_tone(s, 5, 10, DUR);
    push_idle(s + DUR, 5, 5, 1'b1);
    pulse(8'b0010_0000);
    wait_until(s + DUR + 5);

    // Simultaneous press: lowest bit (note 1, half 14) wins.
    s = cyc + 1;
    push_tone(s, 1, 14, DUR);
    push_idle(s + DUR, 5, 1, 1'b1);
    pulse(8'b1000_0110);
    wait_until(s + DUR + 5);

    // Retrigger at tone cycle 40: note 0 (half 16) then note 7 (half 8).
    s = cyc + 1;
    push_tone(s, 0, 16, 40);
    pulse(8'b0000_0001);
    wait_until(s + 39);
    s2 = cyc + 1;
    push_tone(s2, 7, 8, DUR);
    push_idle(s2 + DUR, 5, 7, 1'b1);
    pulse(8'b1000_0000);
    wait_until(s2 + DUR + 5);

    // Expiry collision: note 4 (half 11), then note 3 (half 12) sampled on
    // the edge where the duration counter sits at DUR-1.
    s = cyc + 1;
    push_tone(s, 4, 11, DUR);
    pulse(8'b0001_0000);
    wait_until(s + DUR - 1);
    s2 = cyc + 1;
    push_tone(s2, 3, 12, DUR);
    push_idle(s2 + DUR, 5, 3, 1'b1);
    pulse(8'b0000_1000);
    wait_until(s2 + DUR + 5);

    // Asynchronous reset at tone cycle 50 of note 6, between clock edges.
    s = cyc + 1;
    push_tone(s, 6, 8, 50);
    push_idle(s + 50, 3, 0, 1'b0);
    pulse(8'b0100_0000);
    wait_until(s + 50);
    #1;
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // New tone after release: note 2, half 13.
    s = cyc + 1;
    push_tone(s, 2, 13, DUR);
    push_idle(s + DUR, 5, 2, 1'b1);
    pulse(8'b0000_0100);
    wait_until(s + DUR + 5);

    // Let the monitor drain, bounded.
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      total++;
      $display("FAIL drain: %0d records left, required 0", q.size());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
